// File: rtl/parallel_xor_arb.sv
// Two-requester round-robin arbiter feeding one shared XOR datapath into a
// single-entry result register. Define PARALLEL_XOR_ARB_LOCK_EN to add lock inputs.

module parallel_gate_xor #(
  parameter int unsigned S = 3,
  localparam int unsigned W = 2 ** S
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    assign y[i] = a[i] ^ b[i];
  end

endmodule

module parallel_xor_arb #(
  parameter int unsigned S = 3,
  localparam int unsigned W = 2 ** S
) (
  input  logic         clk,
  input  logic         rst,
`ifdef PARALLEL_XOR_ARB_LOCK_EN
  input  logic         req0_lock,
  input  logic         req1_lock,
`endif
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_id
);

  logic         ptr, ptr_nxt;
  logic         locked, locked_nxt;
  logic         lock_id, lock_id_nxt;
  logic         valid_nxt;
  logic [W-1:0] data_nxt;
  logic         id_nxt;

  logic         slot_free;
  logic         gnt0, gnt1;
  logic         xfer;
  logic         gid;
  logic         lock_req;
  logic [W-1:0] op_a, op_b, xor_y;

  assign slot_free = !out_valid || out_ready;

  // Grant: lock owner first, then the pointer on contention, else the lone requester.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && slot_free) begin
      if (locked) begin
        gnt0 = !lock_id && req0_valid;
        gnt1 = lock_id && req1_valid;
      end else if (req0_valid && req1_valid) begin
        gnt0 = !ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 || gnt1;
  assign gid        = gnt1;

  // Operands are muxed ahead of the single XOR instance.
  assign op_a = gid ? req1_a : req0_a;
  assign op_b = gid ? req1_b : req0_b;

  parallel_gate_xor #(.S(S)) u_xor (
    .a (op_a),
    .b (op_b),
    .y (xor_y)
  );

`ifdef PARALLEL_XOR_ARB_LOCK_EN
  assign lock_req = gid ? req1_lock : req0_lock;
`else
  assign lock_req = 1'b0;
`endif

  // Next-state for the result slot, pointer and lock.
  always_comb begin
    ptr_nxt     = ptr;
    locked_nxt  = locked;
    lock_id_nxt = lock_id;
    valid_nxt   = out_valid;
    data_nxt    = out_data;
    id_nxt      = out_id;
    if (xfer) begin
      valid_nxt = 1'b1;
      data_nxt  = xor_y;
      id_nxt    = gid;
      if (lock_req) begin
        locked_nxt  = 1'b1;
        lock_id_nxt = gid;
      end else begin
        locked_nxt = 1'b0;
        ptr_nxt    = !gid;
      end
    end else if (out_ready) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 1'b0;
      locked    <= 1'b0;
      lock_id   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      locked    <= locked_nxt;
      lock_id   <= lock_id_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_id    <= id_nxt;
    end
  end

endmodule

// File: tb/tb_parallel_xor_arb.sv
// Directed plus randomized checks of parallel_xor_arb against a rule-level model.

module tb_parallel_xor_arb;

`ifdef PARALLEL_XOR_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req0_valid, req1_valid, req0_ready, req1_ready;
  logic       req0_lock, req1_lock;
  logic [7:0] req0_a, req0_b, req1_a, req1_b, out_data;
  logic       out_valid, out_ready, out_id;

  logic       r1_rst, r1_v0, r1_v1, r1_rdy0, r1_rdy1, r1_ov, r1_ordy, r1_id;
  logic       r1_l0, r1_l1;
  logic [0:0] r1_a0, r1_b0, r1_a1, r1_b1, r1_data;

  parallel_xor_arb #(.S(3)) u0 (
    .clk(clk), .rst(rst),
`ifdef PARALLEL_XOR_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  parallel_xor_arb #(.S(0)) u1 (
    .clk(clk), .rst(r1_rst),
`ifdef PARALLEL_XOR_ARB_LOCK_EN
    .req0_lock(r1_l0), .req1_lock(r1_l1),
`endif
    .req0_valid(r1_v0), .req0_ready(r1_rdy0), .req0_a(r1_a0), .req0_b(r1_b0),
    .req1_valid(r1_v1), .req1_ready(r1_rdy1), .req1_a(r1_a1), .req1_b(r1_b1),
    .out_valid(r1_ov), .out_ready(r1_ordy), .out_data(r1_data), .out_id(r1_id)
  );

  int tests = 0;
  int fails = 0;

  // Model state: pointer, lock owner (-1 = none) and the result slot.
  int       m_ptr, m_lock, m_id;
  bit       m_ov;
  bit [7:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = -1; m_ov = 1'b0; m_data = 8'h00; m_id = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    model_reset();
  endtask

  // One cycle: drive, check grant against the model, clock, check the result slot.
  task automatic step(input bit v0, input bit v1, input bit [7:0] a0, input bit [7:0] b0,
                      input bit [7:0] a1, input bit [7:0] b1, input bit ordy,
                      input bit l0, input bit l1, output int g);
    bit lk;
    req0_valid = v0; req1_valid = v1; req0_a = a0; req0_b = b0;
    req1_a = a1; req1_b = b1; out_ready = ordy; req0_lock = l0; req1_lock = l1;
    #1;
    g = -1;
    if (!m_ov || ordy) begin
      if (m_lock >= 0) begin
        if (m_lock == 0 && v0) g = 0;
        if (m_lock == 1 && v1) g = 1;
      end else if (v0 && v1) g = m_ptr;
      else if (v0) g = 0;
      else if (v1) g = 1;
    end
    chk("ready0", req0_ready, 64'(g == 0));
    chk("ready1", req1_ready, 64'(g == 1));
    @(posedge clk); #1;
    if (g >= 0) begin
      m_ov = 1'b1;
      m_data = (g == 1) ? (a1 ^ b1) : (a0 ^ b0);
      m_id = g;
      lk = (g == 1) ? l1 : l0;
      if (LOCK_ON && lk) m_lock = g;
      else begin
        m_lock = -1;
        m_ptr = 1 - g;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    chk("out_valid", out_valid, 64'(m_ov));
    if (m_ov) begin
      chk("out_data", out_data, 64'(m_data));
      chk("out_id", out_id, 64'(m_id));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int exp_g[4];
    bit p0, p1, v0, v1, l0, l1, ordy;
    bit [7:0] a0, b0, a1, b1, held;

    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    req0_lock = 1'b0; req1_lock = 1'b0;
    r1_rst = 1'b1; r1_v0 = 1'b0; r1_v1 = 1'b0; r1_ordy = 1'b1;
    r1_a0 = 1'b0; r1_b0 = 1'b0; r1_a1 = 1'b0; r1_b1 = 1'b0; r1_l0 = 1'b0; r1_l1 = 1'b0;
    model_reset();
    do_reset();

    // Single requester: 0xF0 ^ 0x3C.
    step(1, 0, 8'hF0, 8'h3C, 8'h00, 8'h00, 1, 0, 0, g);
    chk("r032_grant", 64'(g), 0);
    chk("r032_data", out_data, 64'hCC);
    chk("r032_id", out_id, 0);

    // Move the pointer back to 0, then contend for four cycles.
    step(0, 1, 8'h00, 8'h00, 8'h12, 8'h34, 1, 0, 0, g);
    chk("r033_pre_id", out_id, 1);
    exp_g = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      step(1, 1, a0, b0, a1, b1, 1, 0, 0, g);
      chk("r033_grant", 64'(g), 64'(exp_g[i]));
      chk("r033_id", out_id, 64'(exp_g[i]));
      chk("r033_valid", out_valid, 1);
    end

    // Backpressure: hold out_ready low with a result pending.
    step(1, 0, 8'hA5, 8'h0F, 8'h00, 8'h00, 1, 0, 0, g);
    held = out_data;
    chk("r034_held", held, 64'hAA);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h55, 8'h01, 8'h00, 8'h00, 0, 0, 0, g);
      chk("r034_noready", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("r034_stable", out_data, 64'(held));
    end
    step(1, 0, 8'h55, 8'h01, 8'h00, 8'h00, 1, 0, 0, g);
    chk("r034_accept", 64'(g), 0);
    chk("r034_data", out_data, 64'h54);

    // Reset with an unconsumed result; it must never be delivered.
    step(0, 1, 8'h00, 8'h00, 8'h3C, 8'hFF, 0, 0, 0, g);
    chk("r035_pending", out_valid, 1);
    do_reset();
    step(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, g);
    chk("r035_discard", out_valid, 0);
    step(1, 1, 8'h01, 8'h02, 8'h03, 8'h04, 1, 0, 0, g);
    chk("r035_ptr0", 64'(g), 0);

`ifdef PARALLEL_XOR_ARB_LOCK_EN
    do_reset();
    exp_g = '{1, 1, 1, 0};
    step(0, 1, 8'h00, 8'h00, 8'h11, 8'h22, 1, 0, 1, g);
    chk("r036_g0", 64'(g), 64'(exp_g[0]));
    step(1, 1, 8'h33, 8'h44, 8'h55, 8'h66, 1, 0, 1, g);
    chk("r036_g1", 64'(g), 64'(exp_g[1]));
    step(1, 1, 8'h33, 8'h44, 8'h77, 8'h88, 1, 0, 0, g);
    chk("r036_g2", 64'(g), 64'(exp_g[2]));
    step(1, 1, 8'h33, 8'h44, 8'h99, 8'hAA, 1, 0, 0, g);
    chk("r036_g3", 64'(g), 64'(exp_g[3]));
`endif

    // Randomized traffic; unserved requesters hold valid, operands and lock.
    do_reset();
    p0 = 0; p1 = 0;
    v0 = 0; v1 = 0; l0 = 0; l1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!p0) begin
        v0 = 1'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
        l0 = LOCK_ON && ($urandom_range(0, 3) == 0);
      end
      if (!p1) begin
        v1 = 1'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        l1 = LOCK_ON && ($urandom_range(0, 3) == 0);
      end
      ordy = ($urandom_range(0, 3) != 0);
      step(v0, v1, a0, b0, a1, b1, ordy, l0, l1, g);
      p0 = v0 && (g != 0);
      p1 = v1 && (g != 1);
    end

    // One-bit datapath.
    @(posedge clk); #1;
    r1_rst = 1'b0; r1_v0 = 1'b1; r1_a0 = 1'b1; r1_b0 = 1'b1;
    #1;
    chk("r037_ready", r1_rdy0, 1);
    @(posedge clk); #1;
    chk("r037_valid", r1_ov, 1);
    chk("r037_data", r1_data, 0);
    r1_b0 = 1'b0;
    @(posedge clk); #1;
    chk("r037_data2", r1_data, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
